// File: rtl/fnd_bcd_counter_pkg.sv
// Shared constants for the FND BCD counter: active-low 7-segment encodings
// and the BCD-to-segment lookup used by the display driver.
package fnd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes 10..15 never occur in a healthy counter; show them as blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_bcd_counter_digit.sv
// One decade of the BCD chain: steps up or down by one, wrapping 9<->0,
// and flags carry/borrow so the next decade knows when to step.
module fnd_bcd_digit
    import fnd_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       step,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_digit <= 4'd0;
        end else if (clr) begin
            r_digit <= 4'd0;
        end else if (step) begin
            if (up) begin
                r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign digit = r_digit;
    assign cout  = up ? (r_digit == BCD_MAX) : (r_digit == 4'd0);

endmodule

// File: rtl/fnd_bcd_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed common-anode
// 7-segment driver, selectable tick rate and leading-zero blanking.
module fnd_bcd_counter
    import fnd_pkg::*;
#(
    parameter int NDIG    = 8,
    parameter int RATE0   = 1000000,
    parameter int RATE1   = 500000,
    parameter int REFRESH = 125000
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              up,
    input  logic              clksel,
    input  logic              clr,
    input  logic              lzb,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] count,
    output logic              wrap
);

    localparam int RMAX = (RATE0 > RATE1) ? RATE0 : RATE1;
    localparam int PW   = $clog2(RMAX + 1);
    localparam int RW   = $clog2(REFRESH + 1);
    localparam int SW   = $clog2(NDIG);

    localparam logic [PW-1:0] RATE0_LAST   = PW'(RATE0 - 1);
    localparam logic [PW-1:0] RATE1_LAST   = PW'(RATE1 - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH - 1);
    localparam logic [SW-1:0] SCAN_LAST    = SW'(NDIG - 1);

    logic [PW-1:0]   r_presc;
    logic [RW-1:0]   r_refresh;
    logic [SW-1:0]   r_scan;
    logic [6:0]      r_seg;
    logic [NDIG-1:0] r_an;
    logic            r_wrap;

    logic [PW-1:0]   w_rate_last;
    logic            w_tick;
    logic [NDIG:0]   w_chain;
    logic [NDIG-1:0] w_cout;
    logic [NDIG-1:0] w_zero_from;
    logic [NDIG-1:0] w_blank;
    logic [3:0]      w_digit [NDIG];

    // ">=" rather than "==" so a rate switch to a shorter period never overshoots.
    assign w_rate_last = clksel ? RATE1_LAST : RATE0_LAST;
    assign w_tick      = en && (r_presc >= w_rate_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else if (clr) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    assign w_chain[0] = w_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            fnd_bcd_digit u_digit (
                .clk   (clk),
                .rstn  (rstn),
                .step  (w_chain[gi]),
                .up    (up),
                .clr   (clr),
                .digit (w_digit[gi]),
                .cout  (w_cout[gi])
            );
            assign w_chain[gi+1]      = w_chain[gi] & w_cout[gi];
            assign count[4*gi +: 4]   = w_digit[gi];

            if (gi == NDIG - 1) begin : g_top
                assign w_zero_from[gi] = (w_digit[gi] == 4'd0);
            end else begin : g_lower
                assign w_zero_from[gi] = (w_digit[gi] == 4'd0) & w_zero_from[gi+1];
            end

            if (gi == 0) begin : g_units
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = lzb & w_zero_from[gi];
            end
        end
    endgenerate

    // A carry out of the top decade is exactly the wrap event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_chain[NDIG] & ~clr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_refresh <= '0;
            r_scan    <= '0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_scan    <= (r_scan == SCAN_LAST) ? '0 : r_scan + SW'(1);
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(NDIG'(1) << r_scan);
            r_seg <= w_blank[r_scan] ? SEG_BLANK : bcd_to_seg(w_digit[r_scan]);
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_fnd_bcd_counter.sv
// Directed scoreboard bench for fnd_bcd_counter with NDIG=4, RATE0=4,
// RATE1=2, REFRESH=3.
module tb_fnd_bcd_counter;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        up;
    logic        clksel;
    logic        clr;
    logic        lzb;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] count;
    logic        wrap;

    int n_assert = 0;
    int n_fail   = 0;
    int n_edges  = 0;

    string       tag_q [$];
    logic [31:0] exp_q [$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    fnd_bcd_counter #(
        .NDIG    (4),
        .RATE0   (4),
        .RATE1   (2),
        .REFRESH (3)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .up     (up),
        .clksel (clksel),
        .clr    (clr),
        .lzb    (lzb),
        .seg    (seg),
        .an     (an),
        .count  (count),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; drives the expected scan position.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic wait_count(input string t, input logic [31:0] target, input int budget);
        int k;
        k = 0;
        push(t, target);
        while (({16'h0, count} !== target) && (k < budget)) begin
            step(1);
            k++;
        end
        check({16'h0, count});
    endtask

    task automatic scan_check(input string t, input logic [15:0] cnt, input logic blank_lz);
        int          idx;
        logic [3:0]  d;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        upper_zero;
        idx    = ((n_edges - 1) / 3) % 4;
        exp_an = ~(4'b0001 << idx);
        d      = cnt[4*idx +: 4];
        upper_zero = 1'b1;
        for (int j = idx; j < 4; j++) if (cnt[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        exp_seg = (blank_lz && idx != 0 && upper_zero) ? 7'h7F : seg_tab[d];
        push({t, "_an"}, {28'h0, exp_an});
        check({28'h0, an});
        push({t, "_seg"}, {25'h0, exp_seg});
        check({25'h0, seg});
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; up = 1'b1; clksel = 1'b0; clr = 1'b0; lzb = 1'b0;
        step(3);
        push("rst_count", 32'h0);  check({16'h0, count});
        push("rst_an", 32'hF);     check({28'h0, an});
        push("rst_seg", 32'h7F);   check({25'h0, seg});
        push("rst_wrap", 32'h0);   check({31'h0, wrap});

        rstn = 1'b1;
        push("post_rst_e3", 32'h0);    step(3);  check({16'h0, count});
        push("post_rst_e4", 32'h1);    step(1);  check({16'h0, count});
        push("post_rst_e40", 32'h10);  step(36); check({16'h0, count});

        clr = 1'b1; step(1); clr = 1'b0;
        push("clr_count", 32'h0);  check({16'h0, count});
        push("clr_wrap", 32'h0);   check({31'h0, wrap});

        up = 1'b0;
        push("down_e3", 32'h0);       step(3); check({16'h0, count});
        push("down_wrap_cnt", 32'h9999);
        push("down_wrap_pulse", 32'h1);
        step(1); check({16'h0, count}); check({31'h0, wrap});
        push("down_wrap_end", 32'h0);  step(1); check({31'h0, wrap});
        push("down_9998", 32'h9998);   step(3); check({16'h0, count});
        push("down_9998_wrap", 32'h0); check({31'h0, wrap});

        up = 1'b1;
        push("up_9999", 32'h9999);       step(4); check({16'h0, count});
        push("up_9999_nowrap", 32'h0);   check({31'h0, wrap});
        push("up_9999_hold", 32'h9999);  step(3); check({16'h0, count});
        push("up_wrap_cnt", 32'h0);
        push("up_wrap_pulse", 32'h1);
        step(1); check({16'h0, count}); check({31'h0, wrap});
        push("up_wrap_end", 32'h0);      step(1); check({31'h0, wrap});

        // Prescaler now at 2; switching to the 2-cycle rate must tick at once.
        step(1);
        clksel = 1'b1;
        push("sel_overshoot", 32'h1);  step(1); check({16'h0, count});
        push("sel_rate1_e1", 32'h1);   step(1); check({16'h0, count});
        push("sel_rate1_e2", 32'h2);   step(1); check({16'h0, count});
        push("sel_rate1_e4", 32'h3);   step(2); check({16'h0, count});

        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            push("hold_count", 32'h3); check({16'h0, count});
            push("hold_wrap", 32'h0);  check({31'h0, wrap});
        end
        en = 1'b1;
        push("resume_e1", 32'h3);  step(1); check({16'h0, count});
        push("resume_e2", 32'h4);  step(1); check({16'h0, count});

        wait_count("reach_0123", 32'h0123, 600);
        step(1);
        clr = 1'b1; step(1); clr = 1'b0; clksel = 1'b0;
        push("clr_tick_count", 32'h0);  check({16'h0, count});
        push("clr_tick_wrap", 32'h0);   check({31'h0, wrap});
        push("clr_tick_e3", 32'h0);     step(3); check({16'h0, count});
        push("clr_tick_e4", 32'h1);     step(1); check({16'h0, count});

        clksel = 1'b1;
        clr = 1'b1; step(1); clr = 1'b0;
        wait_count("reach_0050", 32'h0050, 300);
        en = 1'b0; lzb = 1'b1;
        step(1);
        for (int i = 0; i < 24; i++) begin
            step(1);
            scan_check("scan_lzb1", 16'h0050, 1'b1);
        end
        lzb = 1'b0;
        step(1);
        for (int i = 0; i < 12; i++) begin
            step(1);
            scan_check("scan_lzb0", 16'h0050, 1'b0);
        end

        en = 1'b1; clksel = 1'b0;
        #2 rstn = 1'b0;
        #1;
        push("async_rst_count", 32'h0);  check({16'h0, count});
        push("async_rst_an", 32'hF);     check({28'h0, an});
        push("async_rst_seg", 32'h7F);   check({25'h0, seg});
        @(posedge clk); #1;
        rstn = 1'b1;
        push("rerun_an_e1", 32'hE);  step(1); check({28'h0, an});
        push("rerun_e3", 32'h0);     step(2); check({16'h0, count});
        push("rerun_e4", 32'h1);     step(1); check({16'h0, count});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
